// File: rtl/jstk_sprite_motion.sv
// Converts PmodJSTK frames, sampled on each 5 Hz strobe, into the sprite's top-left position:
// horizontal stepping from the X axis and a button-triggered jump with gravity on Y.
module jstk_sprite_motion #(
    parameter int IMG_W   = 160,
    parameter int IMG_H   = 120,
    parameter int SCR_W   = 640,
    parameter int SCR_H   = 480,
    parameter int STEP    = 3,
    parameter int DEAD_LO = 400,
    parameter int DEAD_HI = 600,
    parameter int JUMP_V  = 12,
    parameter int GRAVITY = 1,
    parameter int VMAX    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_tick,
    input  logic [39:0] jstk_data,
    output logic [9:0]  img_x,
    output logic [9:0]  img_y,
    output logic        airborne,
    output logic        jump_start
);
    localparam logic [10:0] FLOOR  = 11'(SCR_H - IMG_H);
    localparam logic [10:0] XMAX   = 11'(SCR_W - IMG_W);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] DLO    = 11'(DEAD_LO);
    localparam logic [10:0] DHI    = 11'(DEAD_HI);
    localparam logic [10:0] GRAV_W = 11'(GRAVITY);
    localparam logic [10:0] VMAX_W = 11'(VMAX);
    localparam logic [4:0]  JUMP5  = 5'(JUMP_V);
    localparam logic [4:0]  GRAV5  = 5'(GRAVITY);

    typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;
    state_t state, state_next;

    logic sync1, sync2, sync3, tick;
    logic btn_prev;
    logic [4:0] vel, vel_next;
    logic [10:0] x_w, y_w, vel_w, x_next, y_next;
    logic [10:0] v_up, v_one, v_dn, v_fall;
    logic js_next;

    // Strobe is asynchronous: two flops to synchronise, a third to find the rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            tick  <= 1'b0;
        end else begin
            sync1 <= sample_tick;
            sync2 <= sync1;
            sync3 <= sync2;
            tick  <= sync2 & ~sync3;
        end
    end

    logic [10:0] jx, jy;
    logic btn, left, right, down;
    assign jx    = {1'b0, jstk_data[9:8], jstk_data[23:16]};
    assign jy    = {1'b0, jstk_data[25:24], jstk_data[39:32]};
    assign btn   = jstk_data[0];
    assign left  = jx < DLO;
    assign right = jx > DHI;
    assign down  = jy > DHI;

    assign x_w   = {1'b0, img_x};
    assign y_w   = {1'b0, img_y};
    assign vel_w = {6'd0, vel};

    always_comb begin
        x_next = x_w;
        if (left)
            x_next = (x_w < STEP_W) ? 11'd0 : x_w - STEP_W;
        else if (right)
            x_next = (x_w + STEP_W > XMAX) ? XMAX : x_w + STEP_W;
    end

    // Fall velocity: one gravity step, a second one while the stick is held down, both capped.
    always_comb begin
        v_up   = vel_w + GRAV_W;
        v_one  = (v_up > VMAX_W) ? VMAX_W : v_up;
        v_dn   = v_one + GRAV_W;
        v_fall = down ? ((v_dn > VMAX_W) ? VMAX_W : v_dn) : v_one;
    end

    always_comb begin
        state_next = state;
        y_next     = y_w;
        vel_next   = vel;
        js_next    = 1'b0;
        case (state)
            GROUND: begin
                y_next = FLOOR;
                if (btn & ~btn_prev) begin
                    vel_next   = JUMP5;
                    state_next = RISE;
                    js_next    = 1'b1;
                end
            end
            RISE: begin
                if (y_w < vel_w) begin
                    y_next     = 11'd0;
                    vel_next   = 5'd0;
                    state_next = FALL;
                end else begin
                    y_next   = y_w - vel_w;
                    vel_next = vel - GRAV5;
                    if (vel_w <= GRAV_W)
                        state_next = FALL;
                end
            end
            FALL: begin
                if (y_w + v_fall >= FLOOR) begin
                    y_next     = FLOOR;
                    vel_next   = 5'd0;
                    state_next = GROUND;
                end else begin
                    y_next   = y_w + v_fall;
                    vel_next = v_fall[4:0];
                end
            end
            default: state_next = GROUND;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= GROUND;
        else if (tick)
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            img_x      <= 10'd0;
            img_y      <= FLOOR[9:0];
            vel        <= 5'd0;
            btn_prev   <= 1'b0;
            airborne   <= 1'b0;
            jump_start <= 1'b0;
        end else begin
            jump_start <= tick & js_next;
            if (tick) begin
                img_x    <= x_next[9:0];
                img_y    <= y_next[9:0];
                vel      <= vel_next;
                btn_prev <= btn;
                airborne <= (state_next != GROUND);
            end
        end
    end

    // Frame bits outside the decoded fields, and headroom bits that clamping keeps at zero.
    logic unused_bits;
    assign unused_bits = ^{jstk_data[31:26], jstk_data[15:10], jstk_data[7:1],
                           x_next[10], y_next[10], v_fall[10:5]};
endmodule

// File: tb/tb_jstk_sprite_motion.sv
// Bench for jstk_sprite_motion: constant vector table, hand sequences for strobe timing and
// reset, and random frames checked against a tick-level behavioural model.
module tb_jstk_sprite_motion;
    logic        clk = 1'b0;
    logic        rst;
    logic        sample_tick;
    logic [39:0] jstk_data;
    logic [9:0]  img_x, img_y;
    logic        airborne, jump_start;

    int n_vec = 0;
    int n_err = 0;
    int js_count = 0;

    // Model state: position, velocity, phase (0 ground, 1 rising, 2 falling), last button.
    int m_x, m_y, m_v, m_phase, m_bp;

    typedef struct {
        logic [9:0] x;
        logic       btn;
        int         ex;
        int         ey;
        int         eair;
        int         ejs;
    } vec_t;
    vec_t tbl[$];

    jstk_sprite_motion dut (
        .clk        (clk),
        .rst        (rst),
        .sample_tick(sample_tick),
        .jstk_data  (jstk_data),
        .img_x      (img_x),
        .img_y      (img_y),
        .airborne   (airborne),
        .jump_start (jump_start)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (jump_start === 1'b1) js_count++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [39:0] mk(input logic [9:0] x, input logic [9:0] y, input logic b);
        logic [39:0] f;
        f[31:0]  = $urandom;
        f[39:32] = 8'($urandom);
        f[9:8]   = x[9:8];
        f[23:16] = x[7:0];
        f[25:24] = y[9:8];
        f[39:32] = y[7:0];
        f[0]     = b;
        return f;
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 360; m_v = 0; m_phase = 0; m_bp = 0;
    endtask

    task automatic model_tick(input logic [39:0] f, output int ejs);
        int xv, yv, b, nv;
        xv  = int'({f[9:8], f[23:16]});
        yv  = int'({f[25:24], f[39:32]});
        b   = int'(f[0]);
        ejs = 0;
        if (xv < 400) m_x = (m_x - 3 < 0) ? 0 : m_x - 3;
        else if (xv > 600) m_x = (m_x + 3 > 480) ? 480 : m_x + 3;
        if (m_phase == 0) begin
            m_y = 360;
            if (b == 1 && m_bp == 0) begin
                m_v = 12; m_phase = 1; ejs = 1;
            end
        end else if (m_phase == 1) begin
            if (m_y < m_v) begin
                m_y = 0; m_v = 0; m_phase = 2;
            end else begin
                m_y = m_y - m_v;
                m_v = m_v - 1;
                if (m_v == 0) m_phase = 2;
            end
        end else begin
            nv = (m_v + 1 > 15) ? 15 : m_v + 1;
            if (yv > 600) nv = (nv + 1 > 15) ? 15 : nv + 1;
            if (m_y + nv >= 360) begin
                m_y = 360; m_v = 0; m_phase = 0;
            end else begin
                m_y = m_y + nv; m_v = nv;
            end
        end
        m_bp = b;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        sample_tick = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // One strobe carrying frame f; returns the number of jump_start clocks it produced.
    task automatic send(input logic [39:0] f, output int js);
        int js0;
        @(posedge clk); #2;
        js0 = js_count;
        jstk_data = f;
        sample_tick = 1'b1;
        repeat (6) @(posedge clk);
        #2 sample_tick = 1'b0;
        repeat (5) @(posedge clk);
        #1 js = js_count - js0;
    endtask

    task automatic tick_model(input logic [39:0] f, input string tag);
        int js, ejs;
        send(f, js);
        model_tick(f, ejs);
        check({tag, " img_x"}, 32'(img_x), 32'(m_x));
        check({tag, " img_y"}, 32'(img_y), 32'(m_y));
        check({tag, " airborne"}, 32'(airborne), 32'(m_phase != 0));
        check({tag, " jump_start"}, 32'(js), 32'(ejs));
    endtask

    task automatic add(input logic [9:0] x, input logic b, input int ex, input int ey,
                       input int eair, input int ejs);
        vec_t v;
        v.x = x; v.btn = b; v.ex = ex; v.ey = ey; v.eair = eair; v.ejs = ejs;
        tbl.push_back(v);
    endtask

    initial begin
        int js, js0, ejs, x0;
        int ys[24] = '{348, 337, 327, 318, 310, 303, 297, 292, 288, 285, 283, 282,
                       283, 285, 288, 292, 297, 303, 310, 318, 327, 337, 348, 360};
        logic [39:0] f;

        // Vector table from reset: dead-zone boundaries, then a single tapped jump.
        add(10'd800, 1'b0, 3, 360, 0, 0);
        add(10'd700, 1'b0, 6, 360, 0, 0);
        add(10'd600, 1'b0, 6, 360, 0, 0);
        add(10'd400, 1'b0, 6, 360, 0, 0);
        add(10'd601, 1'b0, 9, 360, 0, 0);
        add(10'd399, 1'b0, 6, 360, 0, 0);
        add(10'd500, 1'b1, 6, 360, 1, 1);
        for (int i = 0; i < 24; i++) add(10'd500, 1'b0, 6, ys[i], (i == 23) ? 0 : 1, 0);

        rst = 1'b1;
        sample_tick = 1'b0;
        jstk_data = '0;
        model_reset();

        // Idle after reset: no strobes, outputs at reset values.
        do_reset();
        js0 = js_count;
        repeat (200) @(posedge clk);
        #1;
        check("idle img_x", 32'(img_x), 32'd0);
        check("idle img_y", 32'(img_y), 32'd360);
        check("idle airborne", 32'(airborne), 32'd0);
        check("idle jump_start", 32'(js_count - js0), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            send(mk(tbl[i].x, 10'd0, tbl[i].btn), js);
            check($sformatf("tbl%0d img_x", i), 32'(img_x), 32'(tbl[i].ex));
            check($sformatf("tbl%0d img_y", i), 32'(img_y), 32'(tbl[i].ey));
            check($sformatf("tbl%0d airborne", i), 32'(airborne), 32'(tbl[i].eair));
            check($sformatf("tbl%0d jump_start", i), 32'(js), 32'(tbl[i].ejs));
        end

        // Stepping right saturates at 480, then left clamps at 0.
        do_reset();
        for (int k = 1; k <= 165; k++) begin
            send(mk(10'd800, 10'd0, 1'b0), js);
            check($sformatf("right%0d", k), 32'(img_x), 32'((3 * k > 480) ? 480 : 3 * k));
        end
        for (int k = 1; k <= 165; k++) begin
            send(mk(10'd100, 10'd0, 1'b0), js);
            check($sformatf("left%0d", k), 32'(img_x), 32'((480 - 3 * k < 0) ? 0 : 480 - 3 * k));
        end

        // Button held through a whole jump and beyond: one jump only, until release and press.
        do_reset();
        js0 = js_count;
        for (int k = 0; k < 30; k++) tick_model(mk(10'd500, 10'd0, 1'b1), "hold");
        check("hold jumps", 32'(js_count - js0), 32'd1);
        tick_model(mk(10'd500, 10'd0, 1'b0), "release");
        tick_model(mk(10'd500, 10'd0, 1'b1), "repress");

        // Strobe latency: outputs move on the 4th clock after the edge; a long high is one update.
        do_reset();
        tick_model(mk(10'd800, 10'd0, 1'b0), "pre");
        x0 = m_x;
        f = mk(10'd800, 10'd0, 1'b1);
        @(posedge clk); #2;
        jstk_data = f;
        sample_tick = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("lat clk%0d img_x", k), 32'(img_x), 32'((k >= 4) ? x0 + 3 : x0));
            check($sformatf("lat clk%0d jump_start", k), 32'(jump_start), 32'(k == 4));
        end
        repeat (1000) @(posedge clk);
        #1;
        model_tick(f, ejs);
        check("long high img_x", 32'(img_x), 32'(m_x));
        check("long high img_y", 32'(img_y), 32'(m_y));
        sample_tick = 1'b0;
        repeat (5) @(posedge clk);

        // Asynchronous reset while rising, then a normal jump.
        do_reset();
        tick_model(mk(10'd500, 10'd0, 1'b1), "rjump");
        for (int k = 0; k < 5; k++) tick_model(mk(10'd500, 10'd0, 1'b0), "rrise");
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("midrst img_y", 32'(img_y), 32'd360);
        check("midrst img_x", 32'(img_x), 32'd0);
        check("midrst airborne", 32'(airborne), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        tick_model(mk(10'd500, 10'd0, 1'b1), "postrst jump");
        tick_model(mk(10'd500, 10'd0, 1'b0), "postrst rise");

        // Random frames against the model.
        do_reset();
        for (int k = 0; k < 200; k++) begin
            tick_model(mk(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                          1'($urandom_range(0, 2) == 0)), $sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
